spi_byte_xmit: RTL and testbench
================================

# spi_byte_xmit

SPI-slave transmit stage for the logic sniffer. It consumes single metadata bytes from the metadata handler (`writeMeta`/`meta_data`), 32-bit sample words from the sampler readout path, and the device-ID request from the command decoder. It serializes them MSB-first onto `spi_miso`, clocked by the host's SPI clock, and reports `xmit_idle` back to its producers.

## Interface
- No parameters. The ID word is fixed: bytes `"1","A","L","S"` (0x31, 0x41, 0x4C, 0x53), sent in that order.
- `clock` in 1: system clock; all logic is on the rising edge.
- `extReset` in 1: synchronous, active-high reset.
- `query_id` in 1: one-cycle pulse requesting the 4-byte ID string.
- `send` in 1: one-cycle pulse requesting a sample word.
- `send_data` in 32: sample word; byte k is bits [8k+7:8k].
- `send_valid` in 4: per-byte enable for `send_data`; bytes whose bit is clear are skipped.
- `writeMeta` in 1: one-cycle pulse requesting the single byte `meta_data`.
- `meta_data` in 8: metadata byte.
- `spi_cs_n` in 1: host chip select, active low, asynchronous to `clock`.
- `spi_sclk` in 1: host SPI clock (mode 0), asynchronous to `clock`.
- `spi_miso` out 1: serial data out.
- `xmit_idle` out 1: registered; high when no byte is held or in flight.

## Operation
- Input sync: `spi_cs_n` and `spi_sclk` each pass through 2 flops. Edge detect uses a third flop on sclk; `sclk_rise` and `sclk_fall` are one-cycle strobes.
- Buffer: 4×8 byte slots plus a 4-bit pending mask.
  - ID request: slots = 31,41,4C,53; mask 1111.
  - Word request: slots = `send_data` bytes; mask = `send_valid`.
  - Meta request: slot0 = `meta_data`; mask 0001.
- Accept only in IDLE.
  - Priority on simultaneous pulses: `query_id` > `send` > `writeMeta`. Losing pulses are dropped.
  - Pulses arriving outside IDLE are dropped. Producers must wait for `xmit_idle`.
  - `send` with `send_valid`==0 is ignored and the block stays IDLE.
- FSM states:
  - IDLE: shift register = 0, bit count = 0. On an accepted request, go to LOAD.
  - LOAD: copy the lowest-index pending slot into the shift register, clear its mask bit, bit count = 0, go to SHIFT.
  - SHIFT:
    - On `sclk_rise`: bit count +1 (saturates at 8).
    - On `sclk_fall` with count < 8: shift left, zero fill.
    - On `sclk_fall` with count == 8: byte done. Go to LOAD if the mask is nonzero, else to IDLE.
- `spi_miso` = shift register bit 7 while synced cs_n is low; otherwise 0.
- Deasserting cs_n while in SHIFT aborts the current byte. The shift register restores that byte from a held copy, count = 0, and the byte restarts from its MSB on the next assertion. Queued bytes are retained.
- `xmit_idle` = (next state == IDLE), registered.
- Reset values: state IDLE, mask 0, shift register 0, count 0, `xmit_idle` 1, `spi_miso` 0, sync flops 1 for cs_n and 0 for sclk.
- Reset mid-transfer discards all pending bytes. The next accept after reset is legal one cycle after `extReset` falls.

## Timing
- Accept to `xmit_idle` low: low in the cycle after the request is sampled. A producer polling the cycle after its pulse sees it low.
- Accept to MSB valid on `spi_miso`: 2 clocks (IDLE→LOAD→SHIFT).
- Pin sclk edge to internal strobe: 3 clocks. Requirement: sclk high and low phases each ≥ 4 `clock` periods.
  - The next byte's MSB is loaded 2 clocks after the internal 8th-falling strobe, i.e. 5 clocks after the pin edge, before the host's next rising edge.
- After the last byte completes, `xmit_idle` rises 1 cycle after the 8th-falling strobe.
- `spi_cs_n` pin change takes effect after 2 clocks.

## Test plan
- Meta byte: `writeMeta` with 0x01, cs low, 8 sclk cycles.
  - Host samples 0,0,0,0,0,0,0,1.
  - `xmit_idle` is low from the cycle after the pulse and high again after the 8th falling edge.
- Masked word: `send` with 0x44332211 and `send_valid`=1011, 24 sclk.
  - Host receives 0x11, 0x22, 0x44.
  - `xmit_idle` stays low throughout.
  - `send_valid`=0000 leaves `xmit_idle` high.
- ID: `query_id`, 32 sclk → host receives 0x31, 0x41, 0x4C, 0x53.
- Priority and drop: `query_id`, `send` and `writeMeta` pulsed in the same cycle.
  - The ID is sent.
  - A `writeMeta` pulse during transfer is never transmitted.
- CS abort: meta byte 0xA5, cs deasserted after 3 sclk cycles, then reasserted with 8 sclk cycles.
  - Host receives the full 0xA5 starting from the MSB.
- Reset mid-word: `extReset` for 1 cycle after byte 0 of a 4-byte word.
  - `spi_miso`=0 and `xmit_idle`=1 the next cycle.
  - A following `writeMeta` 0x02 transmits 0x02 only.

Source files
------------

// File: rtl/spi_byte_xmit.sv
// SPI-slave transmit stage: queues an ID string, a masked sample word or one metadata
// byte, then shifts the bytes out MSB-first on the host's mode-0 SPI clock.
module spi_byte_xmit (
  input  logic        clock,
  input  logic        extReset,
  input  logic        query_id,
  input  logic        send,
  input  logic [31:0] send_data,
  input  logic [3:0]  send_valid,
  input  logic        writeMeta,
  input  logic [7:0]  meta_data,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  output logic        spi_miso,
  output logic        xmit_idle
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] slot_q, slot_d;
  logic [3:0]      mask_q, mask_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      count_q, count_d;
  logic            idle_q, idle_d;

  logic            cs_meta_q, cs_meta_d;
  logic            cs_sync_q, cs_sync_d;
  logic            sclk_meta_q, sclk_meta_d;
  logic            sclk_sync_q, sclk_sync_d;
  logic            sclk_prev_q, sclk_prev_d;

  logic            sclk_rise;
  logic            sclk_fall;
  logic [7:0]      load_byte;
  logic [3:0]      load_mask;

  // Two-flop synchronizers for the host pins, plus a third sclk flop for edge detection.
  always_comb begin
    cs_meta_d   = spi_cs_n;
    cs_sync_d   = cs_meta_q;
    sclk_meta_d = spi_sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

  always_comb begin
    load_byte = 8'h00;
    load_mask = mask_q;
    if (mask_q[0]) begin
      load_byte    = slot_q[0];
      load_mask[0] = 1'b0;
    end else if (mask_q[1]) begin
      load_byte    = slot_q[1];
      load_mask[1] = 1'b0;
    end else if (mask_q[2]) begin
      load_byte    = slot_q[2];
      load_mask[2] = 1'b0;
    end else if (mask_q[3]) begin
      load_byte    = slot_q[3];
      load_mask[3] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        shift_d = 8'h00;
        count_d = 4'd0;
        if (query_id) begin
          slot_d  = {8'h53, 8'h4C, 8'h41, 8'h31};
          mask_d  = 4'b1111;
          state_d = ST_LOAD;
        end else if (send && (send_valid != 4'b0000)) begin
          slot_d  = send_data;
          mask_d  = send_valid;
          state_d = ST_LOAD;
        end else if (writeMeta) begin
          slot_d[0] = meta_data;
          mask_d    = 4'b0001;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (mask_q == 4'b0000) begin
          state_d = ST_IDLE;
        end else begin
          shift_d = load_byte;
          hold_d  = load_byte;
          mask_d  = load_mask;
          count_d = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A deselected host restarts the current byte from its MSB on reselect.
        if (cs_sync_q) begin
          shift_d = hold_q;
          count_d = 4'd0;
        end else if (sclk_rise) begin
          if (count_q != 4'd8) count_d = count_q + 4'd1;
        end else if (sclk_fall) begin
          if (count_q < 4'd8) begin
            shift_d = {shift_q[6:0], 1'b0};
          end else begin
            state_d = (mask_q != 4'b0000) ? ST_LOAD : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (extReset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      mask_q      <= 4'b0000;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      count_q     <= 4'd0;
      idle_q      <= 1'b1;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      mask_q      <= mask_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      cs_meta_q   <= cs_meta_d;
      cs_sync_q   <= cs_sync_d;
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign spi_miso  = shift_q[7] & ~cs_sync_q;
  assign xmit_idle = idle_q;

endmodule

// File: tb/tb_spi_byte_xmit.sv
// Self-checking bench for spi_byte_xmit: acts as an SPI mode-0 host and compares the
// received bytes against expected byte streams from a table and from a request-level model.
module tb_spi_byte_xmit;

  logic        clock = 1'b0;
  logic        extReset;
  logic        query_id;
  logic        send;
  logic [31:0] send_data;
  logic [3:0]  send_valid;
  logic        writeMeta;
  logic [7:0]  meta_data;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_miso;
  logic        xmit_idle;

  int   tests    = 0;
  int   failures = 0;
  logic idle_high_seen;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [3:0]  valid;
    logic [7:0]  meta;
    int          n;
    logic [31:0] expw;
  } vec_t;

  vec_t vecs [7];

  spi_byte_xmit dut (
    .clock      (clock),
    .extReset   (extReset),
    .query_id   (query_id),
    .send       (send),
    .send_data  (send_data),
    .send_valid (send_valid),
    .writeMeta  (writeMeta),
    .meta_data  (meta_data),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_miso   (spi_miso),
    .xmit_idle  (xmit_idle)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // kind: 0 = writeMeta, 1 = send, 2 = query_id
  task automatic applyStimulus(input int kind, input logic [31:0] data,
                               input logic [3:0] valid, input logic [7:0] meta);
    send_data  = data;
    send_valid = valid;
    meta_data  = meta;
    query_id   = (kind == 2);
    send       = (kind == 1);
    writeMeta  = (kind == 0);
    @(negedge clock);
    query_id  = 1'b0;
    send      = 1'b0;
    writeMeta = 1'b0;
  endtask

  // Host side: sample before each rising edge, 8 system clocks per sclk phase.
  task automatic hostByte(output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (xmit_idle) idle_high_seen = 1'b1;
      b = {b[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (8) @(negedge clock);
      spi_sclk = 1'b0;
      repeat (8) @(negedge clock);
    end
  endtask

  // Request-level model: which bytes the host must see, in order.
  function automatic void refModel(input int kind, input logic [31:0] data,
                                   input logic [3:0] valid, input logic [7:0] meta,
                                   output int n, output logic [31:0] expw);
    logic [7:0] id_str [4];
    id_str = '{8'h31, 8'h41, 8'h4C, 8'h53};
    n    = 0;
    expw = 32'h0;
    if (kind == 2) begin
      for (int k = 0; k < 4; k++) expw[8*k +: 8] = id_str[k];
      n = 4;
    end else if (kind == 1) begin
      for (int k = 0; k < 4; k++) begin
        if (valid[k]) begin
          expw[8*n +: 8] = data[8*k +: 8];
          n++;
        end
      end
    end else begin
      expw[7:0] = meta;
      n = 1;
    end
  endfunction

  task automatic runTransfer(input string name, input int kind, input logic [31:0] data,
                             input logic [3:0] valid, input logic [7:0] meta,
                             input int n, input logic [31:0] expw);
    logic [7:0] got;
    applyStimulus(kind, data, valid, meta);
    checkOutput({name, " idle after pulse"}, 32'(xmit_idle), 32'(n == 0));
    if (n == 0) begin
      repeat (10) @(negedge clock);
      checkOutput({name, " idle stays high"}, 32'(xmit_idle), 32'd1);
    end else begin
      repeat (2) @(negedge clock);
      idle_high_seen = 1'b0;
      for (int k = 0; k < n; k++) begin
        hostByte(got);
        checkOutput($sformatf("%s byte%0d", name, k), 32'(got), 32'(expw[8*k +: 8]));
      end
      checkOutput({name, " idle low during"}, 32'(idle_high_seen), 32'd0);
      checkOutput({name, " idle after"}, 32'(xmit_idle), 32'd1);
    end
  endtask

  initial begin
    logic [7:0]  got;
    logic [2:0]  bits;
    int          kind, n;
    logic [31:0] data, expw;
    logic [3:0]  valid;
    logic [7:0]  meta;

    vecs[0] = '{kind: 0, data: 32'h0,        valid: 4'h0,    meta: 8'h01, n: 1, expw: 32'h0000_0001};
    vecs[1] = '{kind: 1, data: 32'h44332211, valid: 4'b1011, meta: 8'h00, n: 3, expw: 32'h0044_2211};
    vecs[2] = '{kind: 1, data: 32'h44332211, valid: 4'b0000, meta: 8'h00, n: 0, expw: 32'h0};
    vecs[3] = '{kind: 2, data: 32'h0,        valid: 4'h0,    meta: 8'h00, n: 4, expw: 32'h534C_4131};
    vecs[4] = '{kind: 1, data: 32'hDEADBEEF, valid: 4'b1111, meta: 8'h00, n: 4, expw: 32'hDEAD_BEEF};
    vecs[5] = '{kind: 1, data: 32'h12345678, valid: 4'b1000, meta: 8'h00, n: 1, expw: 32'h0000_0012};
    vecs[6] = '{kind: 1, data: 32'hCAFEF00D, valid: 4'b0110, meta: 8'h00, n: 2, expw: 32'h0000_FEF0};

    extReset   = 1'b1;
    query_id   = 1'b0;
    send       = 1'b0;
    writeMeta  = 1'b0;
    send_data  = 32'h0;
    send_valid = 4'h0;
    meta_data  = 8'h0;
    spi_cs_n   = 1'b1;
    spi_sclk   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset idle", 32'(xmit_idle), 32'd1);
    checkOutput("reset miso", 32'(spi_miso), 32'd0);
    extReset = 1'b0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("idle before traffic", 32'(xmit_idle), 32'd1);

    for (int v = 0; v < 7; v++)
      runTransfer($sformatf("vec%0d", v), vecs[v].kind, vecs[v].data, vecs[v].valid,
                  vecs[v].meta, vecs[v].n, vecs[v].expw);

    // Simultaneous pulses: ID wins; a meta pulse mid-transfer is dropped.
    send_data  = 32'hDEADBEEF;
    send_valid = 4'hF;
    meta_data  = 8'h77;
    query_id   = 1'b1;
    send       = 1'b1;
    writeMeta  = 1'b1;
    @(negedge clock);
    query_id  = 1'b0;
    send      = 1'b0;
    writeMeta = 1'b0;
    checkOutput("prio idle after pulse", 32'(xmit_idle), 32'd0);
    repeat (2) @(negedge clock);
    idle_high_seen = 1'b0;
    hostByte(got);
    checkOutput("prio byte0", 32'(got), 32'h31);
    meta_data = 8'h99;
    writeMeta = 1'b1;
    @(negedge clock);
    writeMeta = 1'b0;
    hostByte(got);
    checkOutput("prio byte1", 32'(got), 32'h41);
    hostByte(got);
    checkOutput("prio byte2", 32'(got), 32'h4C);
    hostByte(got);
    checkOutput("prio byte3", 32'(got), 32'h53);
    checkOutput("prio idle low during", 32'(idle_high_seen), 32'd0);
    checkOutput("prio idle after", 32'(xmit_idle), 32'd1);
    hostByte(got);
    checkOutput("dropped meta not sent", 32'(got), 32'h00);
    checkOutput("dropped meta idle", 32'(xmit_idle), 32'd1);

    // CS abort after 3 bits, then a full restart of the same byte.
    applyStimulus(0, 32'h0, 4'h0, 8'hA5);
    repeat (2) @(negedge clock);
    bits = 3'b000;
    for (int i = 0; i < 3; i++) begin
      bits = {bits[1:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (8) @(negedge clock);
      spi_sclk = 1'b0;
      repeat (8) @(negedge clock);
    end
    checkOutput("abort first bits", 32'(bits), 32'b101);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("abort miso gated", 32'(spi_miso), 32'd0);
    checkOutput("abort still busy", 32'(xmit_idle), 32'd0);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
    hostByte(got);
    checkOutput("abort restart byte", 32'(got), 32'hA5);
    checkOutput("abort idle after", 32'(xmit_idle), 32'd1);

    // Reset after the first byte of a 4-byte word discards the rest.
    applyStimulus(1, 32'hAABBCCDD, 4'hF, 8'h00);
    repeat (2) @(negedge clock);
    hostByte(got);
    checkOutput("rst word byte0", 32'(got), 32'hDD);
    extReset = 1'b1;
    @(negedge clock);
    extReset = 1'b0;
    checkOutput("rst miso", 32'(spi_miso), 32'd0);
    checkOutput("rst idle", 32'(xmit_idle), 32'd1);
    applyStimulus(0, 32'h0, 4'h0, 8'h02);
    checkOutput("post-rst idle after pulse", 32'(xmit_idle), 32'd0);
    repeat (2) @(negedge clock);
    hostByte(got);
    checkOutput("post-rst meta", 32'(got), 32'h02);
    checkOutput("post-rst idle after", 32'(xmit_idle), 32'd1);
    hostByte(got);
    checkOutput("post-rst no leftovers", 32'(got), 32'h00);

    for (int r = 0; r < 8; r++) begin
      kind  = int'($urandom_range(0, 2));
      data  = $urandom;
      valid = 4'($urandom_range(0, 15));
      meta  = 8'($urandom);
      refModel(kind, data, valid, meta, n, expw);
      runTransfer($sformatf("rand%0d", r), kind, data, valid, meta, n, expw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
